branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage consumer of the ALU status outputs (zero, SF, OF).
- Resolves conditional branches, raises overflow traps for checked ADD/SUB, and drives the front-end redirect handshake.
- Generates a timed flush of younger pipeline stages.
- Sits between the EX stage and the IF/ID control of the five-stage CPU.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays high after the redirect handshake completes; legal range 1..15.
- EXC_VECTOR, 32'h0000_0180, redirect PC used on an overflow trap.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX instruction valid this cycle.
- ex_brtype  in  3  000 none, 001 BEQ, 010 BNE, 011 BGEZ, 100 BLTZ, 101 BGTZ, 110 BLEZ, 111 none.
- ex_ovf_chk  in  1  instruction traps on signed overflow.
- alu_zero  in  1  ALU zero flag.
- alu_sf  in  1  ALU sign flag.
- alu_of  in  1  ALU overflow flag.
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  computed branch target.
- redirect_ready  in  1  IF accepts the redirect.
- redirect_valid  out  1  redirect request.
- redirect_pc  out  32  new fetch PC.
- flush  out  1  kill IF/ID (younger) instructions.
- stall_ex  out  1  EX must hold / ignore new work.
- exc_valid  out  1  one-cycle trap pulse.
- epc  out  32  PC of the trapping instruction.
- flags_q  out  3  registered {zero, SF, OF} of the last accepted instruction.
- br_cnt  out  16  resolved-branch count.
- taken_cnt  out  16  taken-branch count.

Behaviour:
- Reset values (synchronous): state=IDLE; all 1-bit outputs 0; redirect_pc=0; epc=0; flags_q=0; counters=0.
- Taken conditions:
  - BEQ: zero. BNE: !zero.
  - BGEZ: !SF. BLTZ: SF.
  - BGTZ: !SF & !zero. BLEZ: SF | zero.
  - Encodings 000 and 111 are never taken.
- IDLE state, when ex_valid=1:
  - flags_q <= {alu_zero, alu_sf, alu_of}.
  - Trap check first: if ex_ovf_chk & alu_of, then next state REDIR; redirect_pc <= EXC_VECTOR; epc <= ex_pc; exc_valid=1 for exactly the first REDIR cycle.
  - Otherwise, if the branch is taken: next state REDIR; redirect_pc <= ex_target.
  - Otherwise: stay in IDLE; no outputs change except flags_q.
- Priority: a trap wins over a simultaneous taken branch.
- REDIR state:
  - redirect_valid=1. redirect_pc is held stable until redirect_valid & redirect_ready.
  - On the handshake: if FLUSH_CYCLES==1, go to IDLE; otherwise go to FLUSH with cnt=FLUSH_CYCLES-1.
- FLUSH state: decrement cnt each cycle; when cnt reaches 1, go to IDLE.
- Handshake latency: the decision is registered, so redirect_valid rises 1 cycle after the deciding ex_valid cycle.
- flush=1 in REDIR and FLUSH.
- stall_ex=1 whenever state!=IDLE.
- Outside IDLE, ex_valid and all data inputs are ignored (wrong-path instructions). flags_q and the counters are not updated.
- redirect_ready while redirect_valid=0 has no effect.
- rst asserted in any state: IDLE next cycle, redirect_valid and flush drop, and any pending redirect is discarded. Reset mid-handshake therefore loses the redirect; that is intended.
- Total flush length = (REDIR cycles) + FLUSH_CYCLES - 1.

Optional Feature:
- Macro BR_PERF_EN.
- Defined:
  - br_cnt increments on every IDLE ex_valid cycle with brtype in 001..110.
  - taken_cnt increments on every taken branch. Traps count in neither counter.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: br_cnt and taken_cnt are constant 0, and no counter registers are synthesized.

Decomposition:
- Shared package holds:
  - brtype encodings: BR_NONE, BR_BEQ, BR_BNE, BR_BGEZ, BR_BLTZ, BR_BGTZ, BR_BLEZ.
  - state encoding: IDLE, REDIR, FLUSH.
  - the default EXC_VECTOR constant.
- One combinational sub-module, br_cond: inputs brtype, zero and SF; output taken.

Test Plan:
- BEQ taken: ex_valid=1, brtype=001, zero=1, ex_target=32'h0000_0040, redirect_ready=1.
  -> Next cycle redirect_valid=1, redirect_pc=32'h40, flush=1.
  -> With FLUSH_CYCLES=2, flush stays high 1 further cycle, then IDLE; stall_ex mirrors flush.
- Backpressure: BNE with zero=0, redirect_ready low for 3 cycles.
  -> redirect_valid and redirect_pc are held 4 cycles.
  -> ex_valid pulses during the wait are ignored: flags_q unchanged.
- Overflow trap: ex_ovf_chk=1, alu_of=1, brtype=001, zero=1, ex_pc=32'h0000_0100.
  -> exc_valid is a single-cycle pulse.
  -> epc=32'h100, redirect_pc=32'h180 (the trap overrides the branch).
- Signed conditions: sweep BGEZ/BLTZ/BGTZ/BLEZ over (SF, zero) in {00, 01, 10}.
  -> Taken outcomes must match the equations above, e.g. BGTZ with zero=1 is not taken and BLEZ with zero=1 is taken.
- Reset mid-REDIR: assert rst while redirect_valid=1 and redirect_ready=0.
  -> Next cycle all outputs are at reset values, state=IDLE, and the redirect never completes.
- BR_PERF_EN: issue 5 branches, 3 taken, plus 1 trap.
  -> br_cnt=5, taken_cnt=3.
  -> Preload br_cnt to 16'hFFFF via force, then issue another branch: br_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings and constants for the EX-stage branch resolve unit.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BGEZ = 3'b011,
    BR_BLTZ = 3'b100,
    BR_BGTZ = 3'b101,
    BR_BLEZ = 3'b110
  } brtype_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_br_cond.sv
// Branch condition evaluation from the ALU zero and sign flags.
module br_cond
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] brtype,
  input  logic       zero,
  input  logic       sf,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (brtype)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      BR_BGEZ: taken = !sf;
      BR_BLTZ: taken = sf;
      BR_BGTZ: taken = !sf && !zero;
      BR_BLEZ: taken = sf || zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/trap resolution with front-end redirect handshake and timed flush.
// Optional branch statistics counters are built when BR_PERF_EN is defined.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_brtype,
  input  logic        ex_ovf_chk,
  input  logic        alu_zero,
  input  logic        alu_sf,
  input  logic        alu_of,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall_ex,
  output logic        exc_valid,
  output logic [31:0] epc,
  output logic [2:0]  flags_q,
  output logic [15:0] br_cnt,
  output logic [15:0] taken_cnt
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_e     state;
  logic [3:0] cnt;
  logic       taken;
  logic       trap;
  logic       accept;

  br_cond u_br_cond (
    .brtype(ex_brtype),
    .zero  (alu_zero),
    .sf    (alu_sf),
    .taken (taken)
  );

  assign accept = (state == IDLE) && ex_valid;
  assign trap   = ex_ovf_chk && alu_of;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      stall_ex       <= 1'b0;
      exc_valid      <= 1'b0;
      epc            <= '0;
      flags_q        <= '0;
    end else begin
      exc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            flags_q <= {alu_zero, alu_sf, alu_of};
            // A trap overrides any branch outcome of the same instruction.
            if (trap) begin
              state          <= REDIR;
              redirect_valid <= 1'b1;
              redirect_pc    <= EXC_VECTOR;
              epc            <= ex_pc;
              exc_valid      <= 1'b1;
              flush          <= 1'b1;
              stall_ex       <= 1'b1;
            end else if (taken) begin
              state          <= REDIR;
              redirect_valid <= 1'b1;
              redirect_pc    <= ex_target;
              flush          <= 1'b1;
              stall_ex       <= 1'b1;
            end
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 1) begin
              state    <= IDLE;
              flush    <= 1'b0;
              stall_ex <= 1'b0;
            end else begin
              state <= FLUSH;
              cnt   <= FLUSH_INIT;
            end
          end
        end
        FLUSH: begin
          if (cnt == 4'd1) begin
            state    <= IDLE;
            flush    <= 1'b0;
            stall_ex <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          stall_ex       <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_PERF_EN
  logic is_branch;
  assign is_branch = (ex_brtype != BR_NONE) && (ex_brtype != 3'b111);

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (accept && !trap && is_branch) begin
      br_cnt <= sat_inc16(br_cnt);
      if (taken) taken_cnt <= sat_inc16(taken_cnt);
    end
  end
`else
  assign br_cnt    = '0;
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a cycle-level reference model.
module tb_branch_resolve_unit;

  localparam int unsigned FC  = 2;
  localparam logic [31:0] EXC = 32'h0000_0180;
`ifdef BR_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_brtype;
  logic        ex_ovf_chk;
  logic        alu_zero;
  logic        alu_sf;
  logic        alu_of;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall_ex;
  logic        exc_valid;
  logic [31:0] epc;
  logic [2:0]  flags_q;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .EXC_VECTOR(EXC)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_brtype(ex_brtype),
    .ex_ovf_chk(ex_ovf_chk), .alu_zero(alu_zero), .alu_sf(alu_sf), .alu_of(alu_of),
    .ex_pc(ex_pc), .ex_target(ex_target), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .stall_ex(stall_ex), .exc_valid(exc_valid), .epc(epc), .flags_q(flags_q),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the flags are read as the sign of a virtual compare result.
  function automatic bit rule_taken(input logic [2:0] bt, input logic z, input logic s);
    int v;
    v = z ? 0 : (s ? -1 : 1);
    case (bt)
      3'd1: return v == 0;
      3'd2: return v != 0;
      3'd3: return v >= 0;
      3'd4: return v < 0;
      3'd5: return v > 0;
      3'd6: return v <= 0;
      default: return 1'b0;
    endcase
  endfunction

  int          m_phase;  // 0 accepting work, 1 redirect pending, 2 flushing
  int          m_left;
  logic [31:0] m_pc, m_epc;
  logic [2:0]  m_flags;
  logic        m_exc;
  logic [15:0] m_br, m_tk;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_pc = '0; m_epc = '0; m_flags = '0;
      m_exc = 1'b0; m_br = '0; m_tk = '0; m_live = 1'b1;
    end else if (m_live) begin
      m_exc = 1'b0;
      case (m_phase)
        0: if (ex_valid) begin
          m_flags = {alu_zero, alu_sf, alu_of};
          if (ex_ovf_chk && alu_of) begin
            m_phase = 1; m_pc = EXC; m_epc = ex_pc; m_exc = 1'b1;
          end else begin
            if (PERF && ex_brtype >= 3'd1 && ex_brtype <= 3'd6 && m_br != 16'hFFFF) m_br++;
            if (rule_taken(ex_brtype, alu_zero, alu_sf)) begin
              if (PERF && m_tk != 16'hFFFF) m_tk++;
              m_phase = 1; m_pc = ex_target;
            end
          end
        end
        1: if (redirect_ready) begin
          if (FC == 1) m_phase = 0;
          else begin m_phase = 2; m_left = FC - 1; end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_redirect_valid", redirect_valid, (m_phase == 1));
      chk("m_redirect_pc", redirect_pc, m_pc);
      chk("m_flush", flush, (m_phase != 0));
      chk("m_stall_ex", stall_ex, (m_phase != 0));
      chk("m_exc_valid", exc_valid, m_exc);
      chk("m_epc", epc, m_epc);
      chk("m_flags_q", flags_q, m_flags);
      chk("m_br_cnt", br_cnt, m_br);
      chk("m_taken_cnt", taken_cnt, m_tk);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] bt, input logic z, input logic s, input logic of,
                       input logic oc, input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_brtype = bt; alu_zero = z; alu_sf = s; alu_of = of;
    ex_ovf_chk = oc; ex_pc = pc; ex_target = tgt;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (stall_ex && k < 40) begin
      tick();
      k++;
    end
    chk("idle_reached", stall_ex, 1'b0);
  endtask

  bit exp_tbl[4][3] = '{'{1, 1, 0}, '{0, 0, 1}, '{1, 0, 0}, '{0, 1, 1}};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_brtype = 3'd0; ex_ovf_chk = 1'b0;
    alu_zero = 1'b0; alu_sf = 1'b0; alu_of = 1'b0; ex_pc = '0; ex_target = '0;
    redirect_ready = 1'b0;
    repeat (2) tick();
    chk("reset_redirect_valid", redirect_valid, 1'b0);
    chk("reset_redirect_pc", redirect_pc, 32'h0);
    chk("reset_flush", flush, 1'b0);
    rst = 1'b0;

    // BEQ taken, immediate accept
    redirect_ready = 1'b1;
    issue(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0040);
    chk("beq_rv", redirect_valid, 1'b1);
    chk("beq_pc", redirect_pc, 32'h0000_0040);
    chk("beq_flush", flush, 1'b1);
    tick();
    chk("beq_rv_done", redirect_valid, 1'b0);
    chk("beq_flush_hold", flush, 1'b1);
    chk("beq_stall_hold", stall_ex, 1'b1);
    tick();
    chk("beq_flush_end", flush, 1'b0);
    chk("beq_stall_end", stall_ex, 1'b0);

    // BNE taken with backpressure; wrong-path ex_valid pulses ignored
    redirect_ready = 1'b0;
    issue(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0080);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rv_held", redirect_valid, 1'b1);
      chk("bp_pc_held", redirect_pc, 32'h0000_0080);
      ex_valid = 1'b1; alu_zero = 1'b1; alu_sf = 1'b1; alu_of = 1'b1; ex_ovf_chk = 1'b1;
      tick();
    end
    ex_valid = 1'b0;
    chk("bp_rv_held4", redirect_valid, 1'b1);
    chk("bp_flags_kept", flags_q, 3'b000);
    chk("bp_no_exc", exc_valid, 1'b0);
    redirect_ready = 1'b1;
    tick();
    chk("bp_rv_released", redirect_valid, 1'b0);
    wait_idle();

    // Overflow trap beats a taken BEQ
    issue(3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0040);
    chk("trap_exc", exc_valid, 1'b1);
    chk("trap_epc", epc, 32'h0000_0100);
    chk("trap_pc", redirect_pc, 32'h0000_0180);
    chk("trap_flags", flags_q, 3'b101);
    tick();
    chk("trap_exc_pulse", exc_valid, 1'b0);
    wait_idle();

    // Signed conditions over (sf,zero) = 00, 01, 10
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        issue(3'(3 + i), (j == 1), (j == 2), 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0300 + 32'(i * 16 + j));
        chk($sformatf("sweep_bt%0d_c%0d", 3 + i, j), redirect_valid, exp_tbl[i][j]);
        wait_idle();
      end
    end
    issue(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0500);
    chk("none000_not_taken", redirect_valid, 1'b0);
    issue(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0500);
    chk("none111_not_taken", redirect_valid, 1'b0);
    issue(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0500);
    chk("bne_zero_not_taken", redirect_valid, 1'b0);

    // Reset in the middle of a pending redirect
    redirect_ready = 1'b0;
    issue(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'h0000_0044);
    chk("rstmid_rv", redirect_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_rv_drop", redirect_valid, 1'b0);
    chk("rstmid_flush_drop", flush, 1'b0);
    chk("rstmid_pc", redirect_pc, 32'h0);
    chk("rstmid_flags", flags_q, 3'b000);
    redirect_ready = 1'b1;
    tick();
    chk("rstmid_no_complete", redirect_valid, 1'b0);
    chk("rstmid_stall", stall_ex, 1'b0);

    // Statistics: 5 branches, 3 taken, 1 trap
    issue(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0600); wait_idle();
    issue(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0604); wait_idle();
    issue(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0608); wait_idle();
    issue(3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_060C); wait_idle();
    issue(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0610); wait_idle();
    issue(3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0614); wait_idle();
    chk("perf_br_cnt", br_cnt, PERF ? 32'd5 : 32'd0);
    chk("perf_taken_cnt", taken_cnt, PERF ? 32'd3 : 32'd0);
`ifdef BR_PERF_EN
    force dut.br_cnt = 16'hFFFF;
    #1;
    release dut.br_cnt;
    m_br = 16'hFFFF;
    issue(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0800); wait_idle();
    chk("perf_br_saturate", br_cnt, 32'h0000_FFFF);
    chk("perf_taken_after_sat", taken_cnt, 32'd4);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
